// File: rtl/dmem_responder_pkg.sv
// Shared types, default widths and width helpers for the data-memory responder.
package dmem_responder_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage request/response bundle between the pipeline and the data-memory responder.
interface dmem_responder_if
  import dmem_responder_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int CW = 2
);
  logic          req_rd;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_valid;
  logic          busy;
  logic [CW-1:0] sb_count;
  logic          err_sticky;

  modport master (
    output req_rd, req_wr, req_addr, req_wdata,
    input  rsp_rdata, rsp_valid, busy, sb_count, err_sticky
  );

  modport slave (
    input  req_rd, req_wr, req_addr, req_wdata,
    output rsp_rdata, rsp_valid, busy, sb_count, err_sticky
  );
endinterface

// File: rtl/dmem_responder_sb_fifo.sv
// Store buffer: circular FIFO of (address, data) with a parallel lookup that
// reports the youngest valid entry matching the load address.
module dmem_responder_sb_fifo
  import dmem_responder_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int IW    = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [IW-1:0]          push_addr,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  output logic [IW-1:0]          pop_addr,
  output logic [DW-1:0]          pop_data,
  output logic [clog2(DEPTH):0]  count,
  output logic                   full,
  output logic                   empty,
  input  logic [IW-1:0]          lookup_addr,
  output logic                   hit,
  output logic [DW-1:0]          hit_data
);
  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] addr_q [DEPTH];
  logic [IW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [PW-1:0] slot;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    if (push) begin
      addr_d[wr_ptr_q] = push_addr;
      data_d[wr_ptr_q] = push_data;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Walk oldest to youngest so the last match found is the youngest.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    slot     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr_q + PW'(k);
      if (CW'(k) < count_q && addr_q[slot] == lookup_addr) begin
        hit      = 1'b1;
        hit_data = data_q[slot];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: entry storage is not reset; the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign pop_addr = addr_q[rd_ptr_q];
  assign pop_data = data_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: word array with multi-cycle reads, a store
// buffer for single-cycle stores, and combinational load bypass from that buffer.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int AW         = AW_DEF,
  parameter int DEPTH_LOG2 = 8,
  parameter int SB_DEPTH   = 2,
  parameter int RD_LAT     = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);
  localparam int CW    = clog2(SB_DEPTH) + 1;
  localparam int LW    = clog2(RD_LAT + 1);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  state_e                state_q, state_d;
  logic [LW-1:0]         lat_q, lat_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [DW-1:0]         arr_rdata_q;
  logic [DW-1:0]         mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] idx;
  logic                  is_wr, is_rd;
  logic                  sb_push, sb_pop, sb_full, sb_empty, sb_hit;
  logic [DEPTH_LOG2-1:0] sb_pop_addr;
  logic [DW-1:0]         sb_pop_data, sb_hit_data;
  logic [CW-1:0]         sb_count;
  logic                  rd_issue, rsp_valid, busy;
  logic [DW-1:0]         rsp_data;
  logic                  unused_addr_hi;

  // Addresses wrap modulo the array size; a simultaneous read+write is a write.
  assign idx            = bus.req_addr[DEPTH_LOG2-1:0];
  assign unused_addr_hi = ^bus.req_addr[AW-1:DEPTH_LOG2];
  assign is_wr          = bus.req_wr;
  assign is_rd          = bus.req_rd & ~bus.req_wr;

  dmem_responder_sb_fifo #(
    .DW    (DW),
    .IW    (DEPTH_LOG2),
    .DEPTH (SB_DEPTH)
  ) u_sb (
    .clk         (clk),
    .reset       (reset),
    .push        (sb_push),
    .push_addr   (idx),
    .push_data   (bus.req_wdata),
    .pop         (sb_pop),
    .pop_addr    (sb_pop_addr),
    .pop_data    (sb_pop_data),
    .count       (sb_count),
    .full        (sb_full),
    .empty       (sb_empty),
    .lookup_addr (idx),
    .hit         (sb_hit),
    .hit_data    (sb_hit_data)
  );

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    err_d     = err_q | (bus.req_rd & bus.req_wr);
    sb_push   = 1'b0;
    sb_pop    = 1'b0;
    rd_issue  = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    rsp_data  = arr_rdata_q;
    // Gated by reset so outputs fall to their reset values asynchronously.
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (is_wr) begin
            busy    = sb_full;
            sb_push = ~sb_full;
          end else if (is_rd) begin
            if (sb_hit) begin
              rsp_valid = 1'b1;
              rsp_data  = sb_hit_data;
            end else begin
              rd_issue = 1'b1;
              busy     = 1'b1;
              state_d  = RD_WAIT;
              lat_d    = LW'(RD_LAT - 1);
            end
          end
          // A missing read owns the array port this cycle, so drains wait.
          sb_pop = ~sb_empty & ~rd_issue;
        end
        RD_WAIT: begin
          if (lat_q == '0) begin
            rsp_valid = 1'b1;
            state_d   = IDLE;
          end else begin
            busy  = 1'b1;
            lat_d = lat_q - LW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    rdata_d = rsp_valid ? rsp_data : rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lat_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // The array is not written in RD_WAIT, so one synchronous read at issue stays valid.
  always_ff @(posedge clk) begin
    if (sb_pop)   mem_q[sb_pop_addr] <= sb_pop_data;
    if (rd_issue) arr_rdata_q        <= mem_q[idx];
  end

  assign bus.rsp_valid  = rsp_valid;
  assign bus.busy       = busy;
  assign bus.rsp_rdata  = rsp_valid ? rsp_data : rdata_q;
  assign bus.sb_count   = sb_count;
  assign bus.err_sticky = err_q;
endmodule
